host_ram_arbiter: RTL and testbench

HOST_RAM_ARBITER -- requirements
Module: host_ram_arbiter

---
 rtl/host_ram_arb_pkg.sv | 15 +
 rtl/host_ram_arbiter.sv | 112 +++++++++++
 tb/tb_host_ram_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/host_ram_arb_pkg.sv
// Shared types for host_ram_arbiter: FSM state encoding and host mode codes.
package host_ram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_LOAD = 2'b01;
    localparam logic [1:0] MODE_EXEC = 2'b10;

endpackage

// File: rtl/host_ram_arbiter.sv
// Shares one data RAM between a host character loader and the processor data port.
// Define HOST_RAM_ARB_LEN_HEADER_EN to have COMMIT write the character count to BUF_BASE-1.
module host_ram_arbiter
    import host_ram_arb_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int CHAR_W    = 8,
    parameter int BUF_BASE  = 1500,
    parameter int BUF_DEPTH = 108
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [1:0]                     mode,
    input  logic [CHAR_W-1:0]              host_char,
    input  logic                           host_valid,
    output logic                           host_ready,
    input  logic                           host_clear,
    input  logic [ADDR_W-1:0]              rd_addr,
    input  logic [ADDR_W-1:0]              cpu_addr,
    input  logic [DATA_W-1:0]              cpu_wdata,
    input  logic                           cpu_wren,
    output logic [ADDR_W-1:0]              ram_addr,
    output logic [DATA_W-1:0]              ram_wdata,
    output logic                           ram_wren,
    output logic                           cpu_run,
    output logic [$clog2(BUF_DEPTH+1)-1:0] char_count,
    output logic                           buf_full,
    output logic                           overflow
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    state_t state, state_nxt;
    logic   is_full;
    logic   ready_int;
    logic   handshake;
    logic   clear_ok;

    assign is_full   = (char_count == CNT_W'(BUF_DEPTH));
    // Outputs are forced quiet while reset is held, whatever state we came from.
    assign ready_int = (state == ST_LOAD) && !is_full && !host_clear && !reset;
    assign handshake = host_valid && ready_int;
    assign clear_ok  = host_clear && ((state == ST_IDLE) || (state == ST_LOAD));

    always_comb begin
        state_nxt  = state;
        ram_addr   = rd_addr;
        ram_wdata  = '0;
        ram_wren   = 1'b0;
        cpu_run    = 1'b0;
        host_ready = ready_int;
        buf_full   = is_full && !reset;

        case (state)
            ST_IDLE: begin
                if (mode == MODE_LOAD)
                    state_nxt = ST_LOAD;
                else if (mode == MODE_EXEC)
                    state_nxt = ST_EXEC;
            end
            ST_LOAD: begin
                if (handshake) begin
                    ram_addr  = ADDR_W'(BUF_BASE) + ADDR_W'(char_count);
                    ram_wdata = DATA_W'(host_char);
                    ram_wren  = 1'b1;
                end
                if (mode == MODE_EXEC)
                    state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
`ifdef HOST_RAM_ARB_LEN_HEADER_EN
                ram_addr  = ADDR_W'(BUF_BASE - 1);
                ram_wdata = DATA_W'(char_count);
                ram_wren  = !reset;
`endif
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                cpu_run   = !reset;
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_wren  = cpu_wren && !reset;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Idle and reserved mode codes pull every state back to IDLE.
        if ((mode != MODE_LOAD) && (mode != MODE_EXEC))
            state_nxt = ST_IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            char_count <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (clear_ok) begin
                char_count <= '0;
                overflow   <= 1'b0;
            end else begin
                if (handshake)
                    char_count <= char_count + 1'b1;
                if ((state == ST_LOAD) && host_valid && is_full)
                    overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_host_ram_arbiter.sv
// Scoreboard bench for host_ram_arbiter: stimulus queues expected RAM writes, a monitor checks them.
module tb_host_ram_arbiter;
    import host_ram_arb_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int CHAR_W = 8;
    localparam int BASE   = 1500;
    localparam int DEPTH  = 108;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        mode;
    logic [CHAR_W-1:0] host_char;
    logic              host_valid;
    logic              host_ready;
    logic              host_clear;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_wren;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_wren;
    logic              cpu_run;
    logic [CNT_W-1:0]  char_count;
    logic              buf_full;
    logic              overflow;

    host_ram_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CHAR_W(CHAR_W),
        .BUF_BASE(BASE), .BUF_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .host_char(host_char), .host_valid(host_valid), .host_ready(host_ready),
        .host_clear(host_clear), .rd_addr(rd_addr),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_wren(cpu_wren),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren),
        .cpu_run(cpu_run), .char_count(char_count), .buf_full(buf_full),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  mon_total = 0;
    int  mon_bad = 0;
    int  model_cnt = 0;

    // Every RAM write the DUT presents must match the oldest queued expectation.
    always @(negedge clock) begin
        if (ram_wren) begin
            wr_t e;
            mon_total++;
            if (exp_q.size() == 0) begin
                mon_bad++;
                $display("FAIL ram_write_unexpected: got addr=%0d data=0x%0h, required no write",
                         ram_addr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                if (ram_addr !== e.addr || ram_wdata !== e.data) begin
                    mon_bad++;
                    $display("FAIL ram_write: got addr=%0d data=0x%0h, required addr=%0d data=0x%0h",
                             ram_addr, ram_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic send(input logic [7:0] c);
        wr_t e;
        e.addr = ADDR_W'(BASE + model_cnt);
        e.data = DATA_W'(c);
        exp_q.push_back(e);
        host_char  = c;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
        model_cnt++;
    endtask

    initial begin
        wr_t e;
        reset = 1'b1; mode = MODE_IDLE; host_char = '0; host_valid = 1'b0;
        host_clear = 1'b0; rd_addr = '0; cpu_addr = '0; cpu_wdata = '0; cpu_wren = 1'b0;
        tick();
        tick();
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_cpu_run",    32'(cpu_run),    32'd0);
        chk("rst_ram_wren",   32'(ram_wren),   32'd0);
        chk("rst_buf_full",   32'(buf_full),   32'd0);
        chk("rst_count",      32'(char_count), 32'd0);
        chk("rst_overflow",   32'(overflow),   32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_ready", 32'(host_ready), 32'd0);

        // Three characters into the buffer.
        mode = MODE_LOAD;
        tick();
        chk("load_ready", 32'(host_ready), 32'd1);
        rd_addr = 12'd77;
        #1;
        chk("load_idle_addr", 32'(ram_addr), 32'd77);
        chk("load_idle_wren", 32'(ram_wren), 32'd0);
        send(8'h41); send(8'h42); send(8'h43);
        chk("count_3", 32'(char_count), 32'd3);

        // Clear coinciding with a valid character at count 7.
        send(8'h44); send(8'h45); send(8'h46); send(8'h47);
        chk("count_7", 32'(char_count), 32'd7);
        host_char = 8'h55; host_valid = 1'b1; host_clear = 1'b1;
        #1;
        chk("clr_ready", 32'(host_ready), 32'd0);
        chk("clr_wren",  32'(ram_wren),   32'd0);
        tick();
        host_valid = 1'b0; host_clear = 1'b0; model_cnt = 0;
        chk("clr_count",    32'(char_count), 32'd0);
        chk("clr_overflow", 32'(overflow),   32'd0);

        // Fill the buffer, then offer one more character.
        for (int i = 0; i < DEPTH; i++) send(8'(i + 16));
        chk("full_count", 32'(char_count), 32'd108);
        chk("full_flag",  32'(buf_full),   32'd1);
        chk("full_ready", 32'(host_ready), 32'd0);
        host_char = 8'hEE; host_valid = 1'b1;
        #1;
        chk("drop_wren", 32'(ram_wren), 32'd0);
        tick();
        host_valid = 1'b0;
        chk("drop_overflow", 32'(overflow),   32'd1);
        chk("drop_count",    32'(char_count), 32'd108);
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0; model_cnt = 0;
        chk("clr2_count",    32'(char_count), 32'd0);
        chk("clr2_overflow", 32'(overflow),   32'd0);

        // Fifth character accepted in the same cycle that mode switches to exec.
        send(8'h61); send(8'h62); send(8'h63); send(8'h64);
        e.addr = ADDR_W'(BASE + 4); e.data = 32'h65;
        exp_q.push_back(e);
        host_char = 8'h65; host_valid = 1'b1; mode = MODE_EXEC;
        tick();
        host_valid = 1'b0;
        chk("commit_count",   32'(char_count), 32'd5);
        chk("commit_cpu_run", 32'(cpu_run),    32'd0);
`ifdef HOST_RAM_ARB_LEN_HEADER_EN
        e.addr = ADDR_W'(BASE - 1); e.data = 32'd5;
        exp_q.push_back(e);
        chk("commit_wren", 32'(ram_wren), 32'd1);
        chk("commit_addr", 32'(ram_addr), 32'd1499);
`else
        rd_addr = 12'h0AB;
        #1;
        chk("commit_wren", 32'(ram_wren), 32'd0);
        chk("commit_addr", 32'(ram_addr), 32'h0AB);
`endif
        tick();
        chk("exec_cpu_run", 32'(cpu_run), 32'd1);
        cpu_addr = 12'h123; cpu_wdata = 32'hDEADBEEF; cpu_wren = 1'b1;
        e.addr = 12'h123; e.data = 32'hDEADBEEF;
        exp_q.push_back(e);
        #1;
        chk("exec_addr", 32'(ram_addr), 32'h123);
        chk("exec_wren", 32'(ram_wren), 32'd1);
        tick();
        cpu_wren = 1'b0; cpu_addr = 12'h055;
        #1;
        chk("exec_addr2", 32'(ram_addr), 32'h055);
        chk("exec_wren2", 32'(ram_wren), 32'd0);
        chk("exec_count", 32'(char_count), 32'd5);

        // Reserved mode code returns to idle; count persists.
        mode = 2'b11; rd_addr = 12'd300;
        tick();
        chk("rsv_cpu_run", 32'(cpu_run),    32'd0);
        chk("rsv_addr",    32'(ram_addr),   32'd300);
        chk("rsv_count",   32'(char_count), 32'd5);

        // Reset in the middle of a load at count 40.
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0; model_cnt = 0;
        mode = MODE_LOAD;
        tick();
        for (int i = 0; i < 40; i++) send(8'(i + 100));
        chk("mid_count", 32'(char_count), 32'd40);
        reset = 1'b1; host_char = 8'h99; host_valid = 1'b1;
        #1;
        chk("in_rst_ready", 32'(host_ready), 32'd0);
        chk("in_rst_wren",  32'(ram_wren),   32'd0);
        tick();
        reset = 1'b0; host_valid = 1'b0; mode = MODE_IDLE; rd_addr = 12'd1500;
        #1;
        chk("after_rst_count", 32'(char_count), 32'd0);
        chk("after_rst_wren",  32'(ram_wren),   32'd0);
        chk("after_rst_addr",  32'(ram_addr),   32'd1500);
        tick();
        chk("idle_ready", 32'(host_ready), 32'd0);
        chk("idle_addr",  32'(ram_addr),   32'd1500);

        tick();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        total = total + mon_total;
        bad   = bad + mon_bad;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
